// File: rtl/ysyx_22041752_msu_pkg.sv
// Shared widths, load-op encodings, FSM states and the EX->MEM bus layout
// for the memory stage of the RV64 pipeline.
package ysyx_22041752_msu_pkg;

  localparam int XLEN            = 64;
  localparam int RF_DATA_WD      = XLEN;
  localparam int PC_WD           = 64;
  localparam int RF_ADDR_WD      = 5;
  localparam int ES_TO_MS_BUS_WD = 138;
  localparam int MS_TO_WS_BUS_WD = 134;
  localparam int FORWARD_BUS_WD  = 70;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LD  = 3'b011,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101,
    MEM_LWU = 3'b110,
    MEM_RSV = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'b00,
    MS_WAIT  = 2'b01,
    MS_DONE  = 2'b10
  } ms_state_e;

  typedef struct packed {
    logic                  rf_we;
    logic [RF_ADDR_WD-1:0] rd;
    logic                  res_from_mem;
    mem_op_e               mem_op;
    logic [XLEN-1:0]       alu_result;
    logic [PC_WD-1:0]      pc;
  } es_to_ms_t;

endpackage

// File: rtl/ysyx_22041752_load_align.sv
// Shifts the doubleword read data down to the addressed byte and applies
// the sign/zero extension selected by the load opcode.
module ysyx_22041752_load_align
  import ysyx_22041752_msu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  mem_op_e         mem_op,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (mem_op)
      MEM_LB:  data = {{56{shifted[7]}},  shifted[7:0]};
      MEM_LH:  data = {{48{shifted[15]}}, shifted[15:0]};
      MEM_LW:  data = {{32{shifted[31]}}, shifted[31:0]};
      MEM_LBU: data = {56'd0, shifted[7:0]};
      MEM_LHU: data = {48'd0, shifted[15:0]};
      MEM_LWU: data = {32'd0, shifted[31:0]};
      default: data = shifted;  // ld and the reserved encoding
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_msu.sv
// Memory stage: holds one EX result, waits for the load response if needed,
// and passes the aligned result to write-back under valid/allowin.
module ysyx_22041752_msu
  import ysyx_22041752_msu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_rvalid,
  input  logic [XLEN-1:0]            data_rdata,
  output logic                       data_rready,
  output logic [FORWARD_BUS_WD-1:0]  ms_forward_bus,
  output logic                       ms_load_pending
);

  ms_state_e       state_q, state_d;
  es_to_ms_t       bus_q, bus_d;
  logic [XLEN-1:0] hold_q, hold_d;

  logic            ms_valid;
  logic            ms_ready_go;
  logic            entry;
  logic            fwd_valid;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] result;

  always_comb begin
    ms_valid       = (state_q != MS_EMPTY);
    // A response arriving in WAIT completes the stage in the same cycle.
    ms_ready_go    = (state_q == MS_DONE) || ((state_q == MS_WAIT) && data_rvalid);
    ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid && ms_ready_go;
    entry          = es_to_ms_valid && ms_allowin;
    data_rready    = (state_q == MS_WAIT);
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    bus_d   = bus_q;
    hold_d  = hold_q;
    if (entry) begin
      bus_d   = es_to_ms_t'(es_to_ms_bus);
      state_d = es_to_ms_bus[ES_TO_MS_BUS_WD-7] ? MS_WAIT : MS_DONE;
    end else if (ms_to_ws_valid && ws_allowin) begin
      state_d = MS_EMPTY;
    end else if ((state_q == MS_WAIT) && data_rvalid) begin
      // WB is stalled: park the response so it survives past this cycle.
      hold_d  = data_rdata;
      state_d = MS_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MS_EMPTY;
      bus_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      hold_q  <= hold_d;
    end
  end

  assign load_src = (state_q == MS_DONE) ? hold_q : data_rdata;

  ysyx_22041752_load_align u_load_align (
    .rdata  (load_src),
    .offset (bus_q.alu_result[2:0]),
    .mem_op (bus_q.mem_op),
    .data   (load_data)
  );

  assign result          = bus_q.res_from_mem ? load_data : bus_q.alu_result;
  assign fwd_valid       = ms_valid && bus_q.rf_we && ms_ready_go;
  assign ms_to_ws_bus    = {bus_q.rf_we, bus_q.rd, result, bus_q.pc};
  assign ms_forward_bus  = {fwd_valid, result, bus_q.rd};
  assign ms_load_pending = (state_q == MS_WAIT) && !data_rvalid && bus_q.rf_we;

endmodule

// File: tb/tb_ysyx_22041752_msu.sv
// Self-checking bench for the memory stage: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_ysyx_22041752_msu;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [137:0] es_to_ms_bus;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [133:0] ms_to_ws_bus;
  logic         data_rvalid;
  logic [63:0]  data_rdata;
  logic         data_rready;
  logic [69:0]  ms_forward_bus;
  logic         ms_load_pending;

  always #5 clk = ~clk;

  ysyx_22041752_msu dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_rvalid     (data_rvalid),
    .data_rdata      (data_rdata),
    .data_rready     (data_rready),
    .ms_forward_bus  (ms_forward_bus),
    .ms_load_pending (ms_load_pending)
  );

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rd;
    logic        rfm;
    logic [2:0]  op;
    logic [63:0] alu;
    logic [63:0] pc;
  } ins_t;

  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: at most one instruction in flight, plus its response.
  bit          m_valid;
  bit          m_have;
  ins_t        m_ins;
  logic [63:0] m_data;
  bit          last_enter;
  ins_t        drv_ins;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load semantics from the ISA: pick N bytes at the byte offset, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [2:0] off,
                                           input logic [2:0] op);
    int          nbytes;
    bit          sgn;
    logic [63:0] v;
    logic [63:0] mask;
    v = d >> (int'(off) * 8);
    case (op)
      3'd0:    begin nbytes = 1; sgn = 1'b1; end
      3'd1:    begin nbytes = 2; sgn = 1'b1; end
      3'd2:    begin nbytes = 4; sgn = 1'b1; end
      3'd4:    begin nbytes = 1; sgn = 1'b0; end
      3'd5:    begin nbytes = 2; sgn = 1'b0; end
      3'd6:    begin nbytes = 4; sgn = 1'b0; end
      default: begin nbytes = 8; sgn = 1'b0; end
    endcase
    if (nbytes == 8) return v;
    mask = (64'd1 << (nbytes * 8)) - 64'd1;
    v    = v & mask;
    if (sgn && v[nbytes*8-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic send(input logic we, input logic [4:0] rd, input logic rfm,
                      input logic [2:0] op, input logic [63:0] alu, input logic [63:0] pc);
    drv_ins        = '{rf_we: we, rd: rd, rfm: rfm, op: op, alu: alu, pc: pc};
    es_to_ms_bus   = drv_ins;
    es_to_ms_valid = 1'b1;
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0;
    data_rvalid    = 1'b0;
    ws_allowin     = 1'b1;
  endtask

  // Compare every output against the model for the current cycle, advance the
  // model across the coming clock edge, and return at the next falling edge.
  task automatic step();
    logic        rdy;
    logic        allow;
    logic        rready;
    logic [63:0] res;
    #1;
    last_enter = 1'b0;
    if (reset) begin
      m_valid = 1'b0;
      check("rst_allowin", ms_allowin, 1'b1);
      check("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
      check("rst_ws_bus", ms_to_ws_bus, '0);
      check("rst_fwd_bus", ms_forward_bus, '0);
      check("rst_rready", data_rready, 1'b0);
      check("rst_pending", ms_load_pending, 1'b0);
    end else begin
      rdy    = m_valid && (!m_ins.rfm || m_have || data_rvalid);
      res    = m_ins.rfm ? ref_load(m_have ? m_data : data_rdata, m_ins.alu[2:0], m_ins.op)
                         : m_ins.alu;
      allow  = !m_valid || (rdy && ws_allowin);
      rready = m_valid && m_ins.rfm && !m_have;
      check("allowin", ms_allowin, allow);
      check("to_ws_valid", ms_to_ws_valid, rdy);
      check("rready", data_rready, rready);
      check("load_pending", ms_load_pending, rready && !data_rvalid && m_ins.rf_we);
      check("fwd_valid", ms_forward_bus[69], rdy && m_ins.rf_we);
      if (rdy) begin
        check("ws_bus", ms_to_ws_bus, {m_ins.rf_we, m_ins.rd, res, m_ins.pc});
        check("fwd_bus", ms_forward_bus[68:0], {res, m_ins.rd});
      end
      last_enter = es_to_ms_valid && allow;
      if (last_enter) begin
        m_ins   = drv_ins;
        m_valid = 1'b1;
        m_have  = 1'b0;
      end else if (rdy && ws_allowin) begin
        m_valid = 1'b0;
      end else if (rready && data_rvalid) begin
        m_have = 1'b1;
        m_data = data_rdata;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    ws_allowin     = 1'b1;
    data_rvalid    = 1'b0;
    data_rdata     = '0;
    m_valid        = 1'b0;
    m_have         = 1'b0;
    m_ins          = '0;
    m_data         = '0;
    drv_ins        = '0;
    step();
    step();
    reset = 1'b0;
    step();

    // ALU result passes through one cycle after entry.
    send(1'b1, 5'd5, 1'b0, 3'd0, 64'h1234, 64'h8000_0000);
    step();
    idle();
    #1;
    check("t1_valid", ms_to_ws_valid, 1'b1);
    check("t1_result", ms_to_ws_bus[127:64], 64'h1234);
    check("t1_rd", ms_to_ws_bus[132:128], 5'd5);
    check("t1_fwd_valid", ms_forward_bus[69], 1'b1);
    check("t1_rready", data_rready, 1'b0);
    step();

    // lb at offset 3, response after two waiting cycles.
    send(1'b1, 5'd7, 1'b1, 3'd0, 64'h1003, 64'h8000_0004);
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t2_pending", ms_load_pending, 1'b1);
      check("t2_allowin", ms_allowin, 1'b0);
      step();
    end
    data_rvalid = 1'b1;
    data_rdata  = 64'h0000_0000_80FF_0000;
    #1;
    check("t2_valid", ms_to_ws_valid, 1'b1);
    check("t2_result", ms_to_ws_bus[127:64], 64'hFFFF_FFFF_FFFF_FF80);
    step();
    idle();

    // lwu answered while WB stalls; the held data must survive.
    send(1'b1, 5'd9, 1'b1, 3'd6, 64'h2004, 64'h8000_0008);
    step();
    idle();
    ws_allowin  = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 64'h8765_4321_0000_0000;
    step();
    data_rvalid = 1'b0;
    data_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_hold", ms_to_ws_bus[127:64], 64'h0000_0000_8765_4321);
      check("t3_allowin", ms_allowin, 1'b0);
      step();
    end
    ws_allowin = 1'b1;
    #1;
    check("t3_xfer", ms_to_ws_bus[127:64], 64'h0000_0000_8765_4321);
    step();
    #1;
    check("t3_empty", ms_to_ws_valid, 1'b0);
    step();

    // Back-to-back ALU ops: no bubble.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 5'(i + 1), 1'b0, 3'd0, {$urandom, $urandom}, 64'h9000_0000 + 64'(i * 4));
      #1;
      check("t4_allowin", ms_allowin, 1'b1);
      if (i > 0) check("t4_valid", ms_to_ws_valid, 1'b1);
      step();
    end
    idle();
    step();

    // Reset while waiting; a late response is dropped.
    send(1'b1, 5'd3, 1'b1, 3'd3, 64'h3000, 64'h8000_0010);
    step();
    idle();
    step();
    reset = 1'b1;
    step();
    reset       = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = {$urandom, $urandom};
    #1;
    check("t5_rready", data_rready, 1'b0);
    check("t5_valid", ms_to_ws_valid, 1'b0);
    step();
    idle();
    send(1'b1, 5'd4, 1'b0, 3'd0, 64'h55, 64'h8000_0014);
    step();
    idle();
    #1;
    check("t5_next", ms_to_ws_bus[127:64], 64'h55);
    step();

    // Response during the entry cycle is not accepted.
    send(1'b1, 5'd6, 1'b1, 3'd3, 64'h4000, 64'h8000_0018);
    data_rvalid = 1'b1;
    data_rdata  = 64'hDEAD;
    #1;
    check("t6_rready_empty", data_rready, 1'b0);
    step();
    idle();
    #1;
    check("t6_pending", ms_load_pending, 1'b1);
    step();
    data_rvalid = 1'b1;
    data_rdata  = 64'h1122_3344_5566_7788;
    #1;
    check("t6_result", ms_to_ws_bus[127:64], 64'h1122_3344_5566_7788);
    step();
    idle();
    step();

    // Randomized traffic with WB back-pressure and stray responses.
    for (int c = 0; c < 600; c++) begin
      ws_allowin = ($urandom_range(0, 3) != 0);
      if (!es_to_ms_valid || last_enter) begin
        if ($urandom_range(0, 9) < 7)
          send(1'($urandom), 5'($urandom), 1'($urandom), 3'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom});
        else
          es_to_ms_valid = 1'b0;
      end
      if (m_valid && m_ins.rfm && !m_have)
        data_rvalid = ($urandom_range(0, 2) == 0);
      else
        data_rvalid = ($urandom_range(0, 15) == 0);
      data_rdata = {$urandom, $urandom};
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
